// File: rtl/mux_stream_arb_if.sv
// Stream bundle between N producers and one consumer around the arbitrating mux.
// The slave modport is the arbiter's view, the master modport is the environment's view.
interface mux_stream_arb_if #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = $clog2(CHANNELS)
);
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [SEL_W-1:0]          out_chan;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid,
        input  out_chan
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid,
        output out_chan
    );
endinterface

// File: rtl/mux_stream_arb.sv
// N-channel stream multiplexer: arbitrates among valid producers (round-robin or
// fixed lowest-index priority) and forwards one beat per cycle into a registered
// output stage with a valid/ready handshake on both sides.
module mux_stream_arb #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter bit          RR_MODE  = 1'b1
) (
    input logic             clk,
    input logic             rst_n,
    mux_stream_arb_if.slave bus
);
    localparam int unsigned SEL_W = $clog2(CHANNELS);

    // Output stage and round-robin pointer
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_chan_q, out_chan_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    // Arbitration results
    logic [CHANNELS-1:0] grant_oh;
    logic [SEL_W-1:0]    grant_idx;
    logic [WIDTH-1:0]    grant_data;
    logic                any_grant;
    logic                load;
    logic                accept;
    int                  start;
    int                  idx;

    // Output register may take a new beat when empty or being drained this cycle
    always_comb begin
        load   = !out_valid_q || bus.out_ready;
        accept = load && any_grant && rst_n;
    end

    // Arbiter: scan channels in priority order, first valid one wins
    always_comb begin
        grant_oh   = '0;
        grant_idx  = '0;
        grant_data = '0;
        any_grant  = 1'b0;
        idx        = 0;
        // Round-robin starts just past the last served channel; fixed priority at 0
        start      = RR_MODE ? (int'(ptr_q) + 1) : 0;
        for (int k = 0; k < int'(CHANNELS); k++) begin
            idx = (start + k) % int'(CHANNELS);
            if (!any_grant && bus.in_valid[idx]) begin
                any_grant     = 1'b1;
                grant_oh[idx] = 1'b1;
                grant_idx     = SEL_W'(idx);
                grant_data    = bus.in_data[idx*WIDTH +: WIDTH];
            end
        end
    end

    // Next state of the output stage and pointer
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_chan_d  = grant_idx;
            if (RR_MODE) begin
                ptr_d = grant_idx;
            end
        end else if (load) begin
            // Drained (or already empty) with nothing new: data/chan keep last values
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr_q       <= SEL_W'(CHANNELS - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
        end
    end

    // Drive the bundle: ready is gated so nothing is accepted while in reset
    always_comb begin
        bus.in_ready  = (load && rst_n) ? grant_oh : '0;
        bus.out_valid = out_valid_q;
        bus.out_data  = out_data_q;
        bus.out_chan  = out_chan_q;
    end
endmodule
